// File: rtl/battle_board_engine.sv
// battle_board_engine: ship map storage, attack classification and LED matrix scan for a COLSxROWS board
module battle_board_engine #(
    parameter int COLS         = 5,
    parameter int ROWS         = 7,
    parameter int COORD_W      = 3,
    parameter int SCAN_DIV     = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           status,
    input  logic                 load_map,
    input  logic [COLS*ROWS-1:0] ship_map,
    input  logic                 attack,
    input  logic [COORD_W-1:0]   col_attack,
    input  logic [COORD_W-1:0]   row_attack,
    output logic [COLS-1:0]      columns,
    output logic [ROWS-1:0]      lines,
    output logic [1:0]           attack_result,
    output logic                 result_valid,
    output logic [6:0]           remaining,
    output logic                 game_over
);
    localparam int N  = COLS * ROWS;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;
    state_t state_q;
    logic [N-1:0] ships_q, hit_q, miss_q, cell_mask;
    logic [COORD_W-1:0] col_q, row_q;
    logic [6:0] remaining_q, pop_map;
    logic game_over_q, valid_q, in_range, is_ship, is_repeat;
    logic [1:0] result_q;
    logic [CW-1:0] idx_q, idx_d;
    logic [DW-1:0] div_q, div_d;
    logic [FW-1:0] frame_q, frame_d;
    logic blink_q, blink_d, div_wrap, col_wrap, frame_tick;
    logic [COLS-1:0] columns_q, columns_d;
    logic [ROWS-1:0] lines_q, lines_d, ship_col, hit_col, miss_col;
    // Classify the latched coordinate and count ship cells in the incoming map
    always_comb begin
        in_range  = (int'(col_q) < COLS) && (int'(row_q) < ROWS);
        cell_mask = in_range ? N'(1) << (int'(col_q) * ROWS + int'(row_q)) : '0;
        is_ship   = |(ships_q & cell_mask);
        is_repeat = |((hit_q | miss_q) & cell_mask);
        pop_map   = '0;
        for (int i = 0; i < N; i++) pop_map = pop_map + 7'(ship_map[i]);
    end
    // Attack FSM plus map, remaining-cell and game-over state; a load in positioning overrides everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ships_q     <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            remaining_q <= '0;
            game_over_q <= 1'b0;
            result_q    <= 2'b00;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (attack && status == 2'b10 && !game_over_q) begin
                    state_q <= CHECK;
                    col_q   <= col_attack;
                    row_q   <= row_attack;
                end
                CHECK: begin
                    state_q <= REPORT;
                    valid_q <= 1'b1;
                    if (!in_range) result_q <= 2'b11;
                    else if (is_repeat) result_q <= 2'b10;
                    else if (is_ship) begin
                        result_q <= 2'b01;
                        hit_q    <= hit_q | cell_mask;
                        if (remaining_q != 7'd0) remaining_q <= remaining_q - 7'd1;
                        if (remaining_q == 7'd1) game_over_q <= 1'b1;
                    end else begin
                        result_q <= 2'b00;
                        miss_q   <= miss_q | cell_mask;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (load_map && status == 2'b01) begin
                ships_q     <= ship_map;
                hit_q       <= '0;
                miss_q      <= '0;
                remaining_q <= pop_map;
                game_over_q <= 1'b0;
            end
        end
    end
    // Next scan position, blink phase and the row pattern for the column about to be selected
    always_comb begin
        div_wrap   = div_q == DW'(SCAN_DIV - 1);
        col_wrap   = idx_q == CW'(COLS - 1);
        frame_tick = div_wrap && col_wrap;
        div_d      = div_wrap ? '0 : div_q + 1'b1;
        idx_d      = div_wrap ? (col_wrap ? '0 : idx_q + 1'b1) : idx_q;
        frame_d    = frame_tick ? (frame_q == FW'(BLINK_FRAMES - 1) ? '0 : frame_q + 1'b1) : frame_q;
        blink_d    = blink_q ^ (frame_tick && frame_q == FW'(BLINK_FRAMES - 1));
        ship_col   = ROWS'(ships_q >> (int'(idx_d) * ROWS));
        hit_col    = ROWS'(hit_q >> (int'(idx_d) * ROWS));
        miss_col   = ROWS'(miss_q >> (int'(idx_d) * ROWS));
        columns_d  = COLS'(1) << idx_d;
        lines_d    = status == 2'b00 ? '0 :
                     status == 2'b01 ? ship_col :
                     status == 2'b10 ? hit_col | (miss_col & {ROWS{blink_d}}) :
                                       hit_col | (ship_col & ~hit_col & {ROWS{blink_d}});
    end
    // Scan registers; columns and lines update together so no column ever shows a neighbour's rows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            div_q     <= '0;
            frame_q   <= '0;
            blink_q   <= 1'b0;
            columns_q <= COLS'(1);
            lines_q   <= '0;
        end else begin
            idx_q     <= idx_d;
            div_q     <= div_d;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
            columns_q <= columns_d;
            lines_q   <= lines_d;
        end
    end
    assign columns       = columns_q;
    assign lines         = lines_q;
    assign attack_result = result_q;
    assign result_valid  = valid_q;
    assign remaining     = remaining_q;
    assign game_over     = game_over_q;
endmodule

// File: tb/tb_battle_board_engine.sv
// tb_battle_board_engine: scoreboard bench for attack results plus directed scan and blink checks
module tb_battle_board_engine;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] status = 2'b00;
    logic load_map = 1'b0, attack = 1'b0;
    logic [34:0] ship_map = '0;
    logic [2:0] col_attack = '0, row_attack = '0;
    logic [4:0] columns, columns2;
    logic [6:0] lines, lines2, remaining, remaining2;
    logic [1:0] attack_result, attack_result2;
    logic result_valid, result_valid2, game_over, game_over2;
    typedef struct {logic [1:0] res; logic [6:0] rem; logic go; int at;} exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc, n_chk = 0, n_fail = 0;
    logic scan_chk = 1'b0;
    localparam logic [34:0] MAP = 35'd3 | (35'd1 << 34);

    battle_board_engine u_dut (
        .clk(clk), .reset(reset), .status(status), .load_map(load_map), .ship_map(ship_map),
        .attack(attack), .col_attack(col_attack), .row_attack(row_attack), .columns(columns),
        .lines(lines), .attack_result(attack_result), .result_valid(result_valid),
        .remaining(remaining), .game_over(game_over)
    );
    battle_board_engine #(.SCAN_DIV(2), .BLINK_FRAMES(2)) u_scan (
        .clk(clk), .reset(reset), .status(status), .load_map(load_map), .ship_map(ship_map),
        .attack(attack), .col_attack(col_attack), .row_attack(row_attack), .columns(columns2),
        .lines(lines2), .attack_result(attack_result2), .result_valid(result_valid2),
        .remaining(remaining2), .game_over(game_over2)
    );

    always #5 clk = ~clk;
    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic attack_go(input int c, input int r, input logic push, input logic [1:0] res,
                             input logic [6:0] rem, input logic go);
        exp_t x;
        col_attack = 3'(c);
        row_attack = 3'(r);
        attack = 1'b1;
        if (push) begin
            x.res = res; x.rem = rem; x.go = go; x.at = cyc + 2;
            sb.push_back(x);
        end
        @(negedge clk);
        attack = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load(input logic [34:0] m);
        ship_map = m;
        load_map = 1'b1;
        @(negedge clk);
        load_map = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every strobe and checks the slow-scan instance when armed
    always @(negedge clk) begin
        if (result_valid) begin
            chk("strobe_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("attack_result", attack_result, e.res);
                chk("remaining", remaining, e.rem);
                chk("game_over", game_over, e.go);
                chk("latency", cyc, e.at);
            end
        end
        if (scan_chk) begin
            chk("scan_columns", columns2, 32'(5'b1 << ((cyc / 2) % 5)));
            if (columns2 == 5'b00100) chk("blink_line", lines2[3], ((cyc / 10) / 2) % 2);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_columns", columns, 1);
        chk("rst_lines", lines, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_result", attack_result, 0);
        chk("rst_valid", result_valid, 0);
        reset = 1'b0;
        status = 2'b01;
        load(MAP);
        chk("remaining_load", remaining, 3);
        @(negedge clk);
        for (int i = 0; i < 20 && columns !== 5'b00001; i++) @(negedge clk);
        chk("scan_col0_seen", columns, 5'b00001);
        chk("scan_col0_lines", lines, 7'b0000011);
        for (int i = 0; i < 20 && columns !== 5'b10000; i++) @(negedge clk);
        chk("scan_col4_seen", columns, 5'b10000);
        chk("scan_col4_lines", lines, 7'b1000000);
        status = 2'b10;
        attack_go(0, 0, 1'b1, 2'b01, 7'd2, 1'b0);
        attack_go(2, 3, 1'b1, 2'b00, 7'd2, 1'b0);
        attack_go(0, 0, 1'b1, 2'b10, 7'd2, 1'b0);
        attack_go(5, 0, 1'b1, 2'b11, 7'd2, 1'b0);
        attack_go(0, 7, 1'b1, 2'b11, 7'd2, 1'b0);
        chk("result_holds", attack_result, 2'b11);
        e.res = 2'b01; e.rem = 7'd1; e.go = 1'b0; e.at = cyc + 2;
        sb.push_back(e);
        col_attack = 3'd0; row_attack = 3'd1; attack = 1'b1;
        @(negedge clk);
        col_attack = 3'd4; row_attack = 3'd6;
        @(negedge clk);
        attack = 1'b0;
        repeat (4) @(negedge clk);
        chk("remaining_after_drop", remaining, 1);
        attack_go(4, 6, 1'b1, 2'b01, 7'd0, 1'b1);
        attack_go(1, 1, 1'b0, 2'b00, 7'd0, 1'b0);
        chk("game_over_sticky", game_over, 1);
        load(35'd1);
        chk("load_ignored_rem", remaining, 0);
        chk("load_ignored_go", game_over, 1);
        status = 2'b01;
        load(MAP);
        chk("reload_go", game_over, 0);
        chk("reload_rem", remaining, 3);
        status = 2'b10;
        col_attack = 3'd0; row_attack = 3'd0; attack = 1'b1;
        @(negedge clk);
        attack = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_columns", columns, 1);
        chk("midrst_lines", lines, 0);
        chk("midrst_remaining", remaining, 0);
        chk("midrst_result", attack_result, 0);
        chk("midrst_valid", result_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        status = 2'b01;
        load(MAP);
        status = 2'b10;
        attack_go(2, 3, 1'b1, 2'b00, 7'd3, 1'b0);
        for (int i = 0; i < 100 && cyc < 30; i++) @(negedge clk);
        scan_chk = 1'b1;
        repeat (80) @(negedge clk);
        scan_chk = 1'b0;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
